apb_field_bank: RTL
===================

# apb_field_bank

Parametrised APB4 register bank of `N_REGS` single-field registers, each `FIELD_W` bits wide, with a per-register hardware-access mode chosen at elaboration time. It generalises the fixed per-field register wrappers used in the field-type test benches. It sits between the APB bus and core logic, exposing a flat `hwif_in_*` / `hwif_out_*` vector interface. A sticky-bit interrupt output is included.

## Interface
Parameters:
- `G_ADDR_WIDTH`, default 6: APB address width in bits; must be at least clog2(`N_REGS`·4).
- `N_REGS`, default 8: number of registers, 1..16. Register i is at byte address 4·i.
- `FIELD_W`, default 8: field width in bits, 1..32. The field occupies `prdata`/`pwdata` bits [`FIELD_W`-1:0].
- `MODE`, default 0: 2·`N_REGS`-bit vector. `MODE`[2i+1:2i] selects the mode of register i.
- `RESET_VAL`, default 0: `N_REGS`·`FIELD_W`-bit vector. Slice i is the reset value of register i.

Ports (single clock `clk`; `rst` is synchronous and active-low, asserted when 0):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-low reset.
- `s_apb_psel`, `s_apb_penable`, `s_apb_pwrite`  in  1 each  APB control.
- `s_apb_pprot`  in  3  ignored.
- `s_apb_paddr`  in  `G_ADDR_WIDTH`  byte address; bits [1:0] ignored.
- `s_apb_pwdata`  in  32  write data.
- `s_apb_pstrb`  in  4  byte-lane write strobes.
- `s_apb_pready`  out  1  transfer complete.
- `s_apb_prdata`  out  32  read data; bits above `FIELD_W` read 0.
- `s_apb_pslverr`  out  1  error response.
- `hwif_in_next`  in  `N_REGS`·`FIELD_W`  hardware next value per register.
- `hwif_in_we`  in  `N_REGS`  hardware write qualifier per register. Active-high in modes 1 and 3; active-low in mode 2.
- `hwif_out_value`  out  `N_REGS`·`FIELD_W`  current register values.
- `irq`  out  1  OR of all bits of all mode-3 registers.

## Operation
Modes:
- Mode 0, RW: software read/write. `hwif_in_*` slices are ignored.
- Mode 1, RW_HWWE: software read/write. When `hwif_in_we`[i]=1, the register loads `hwif_in_next` slice i.
- Mode 2, RW_HWWEL: as mode 1, but the load occurs when `hwif_in_we`[i]=0.
- Mode 3, W1C_STICKY:
  - A hardware set occurs when `we`=1: value |= next.
  - A software write clears every bit written as 1; bits written as 0 are unchanged.

Byte-lane strobes:
- Field bits in byte lane k change from a software write only if `s_apb_pstrb`[k]=1.
- In mode 3, a byte lane with strobe 0 clears nothing.

Simultaneous software and hardware update in the same cycle:
- Modes 1 and 2: the hardware load wins and the software write is lost.
- Mode 3: per bit, new = (value & ~clr) | set, so a set wins over a clear.

Decode:
- Index = `s_apb_paddr`[`G_ADDR_WIDTH`-1:2].
- Index ≥ `N_REGS` is out of range: the write is dropped and the read returns 0.

Control FSM:
- IDLE → ACK when `psel`&`penable` are sampled high.
- ACK → IDLE unconditionally.
- The write commits on the IDLE→ACK edge. `prdata`/`pslverr` are registered on that same edge and reflect pre-write state.
- `pready`=1 only in ACK. `prdata`=0 in ACK for writes and in IDLE.

## Timing
- Each APB transfer takes a setup cycle plus two access cycles, i.e. one wait state.
- The value written by software appears on `hwif_out_value` in the ACK cycle.
- A hardware load sampled at edge N is visible on `hwif_out_value` and readable after edge N.
- `irq` is registered and asserts one cycle after the sticky bit sets.
- If `psel` drops during the first access cycle: no commit, FSM stays IDLE.
- Back-to-back transfers: the next setup cycle may follow ACK directly.
- Reset, which overrides everything including a transfer in progress:
  - values ← `RESET_VAL`
  - FSM ← IDLE
  - `pready`, `prdata`, `pslverr`, `irq` ← 0
  - no commit in the reset cycle.

## Configuration
- `APB_FIELD_BANK_SLVERR_EN` defined: an out-of-range access asserts `s_apb_pslverr`=1 in its ACK cycle.
- Not defined: `s_apb_pslverr` is tied to 0 and out-of-range accesses complete silently.
- In both builds, out-of-range writes are dropped and out-of-range reads return 0.

## Test plan
- **Reset and readback.** Use `RESET_VAL` slice 2=0x5A and hold `rst`=0 for 3 cycles, then read address 0x08. Expect 0x5A with `pready` in the second access cycle, and `hwif_out_value` slice 2 = 0x5A.
- **Mode 1 collision.** Software writes 0x11 to reg 1 in the cycle `hwif_in_we`[1]=1 with next=0x22. Expect value 0x22; a readback returns 0x22.
- **Mode 2 polarity.** With `we`[2]=1, software writes 0x33 and it holds. Then drive `we`[2]=0 with next=0x44. Expect value 0x44 one cycle later.
- **Mode 3 sticky / W1C.**
  - Pulse set 0x81 → `irq`=1.
  - Write 0x01 → value 0x80, `irq` still 1.
  - Write 0x80 with `pstrb`=0 → no change.
  - Write 0x80 with `pstrb`=1 → value 0, `irq`=0.
- **Out-of-range access.** Read address 0x3C with `N_REGS`=8. Expect `prdata`=0, with `pslverr`=1 only when the macro is defined. A write to the same address leaves all registers unchanged.
- **Mid-transfer reset and abort.**
  - `rst` low in the first access cycle of a write → no commit, `pready` stays 0.
  - `psel` dropped in the same cycle → FSM remains IDLE.

Source files
------------

// File: rtl/apb_field_bank.sv
// apb_field_bank: APB4 bank of N_REGS single-field registers, each with an
// elaboration-time hardware access mode (RW, RW_HWWE, RW_HWWEL, W1C_STICKY).
// Build macro APB_FIELD_BANK_SLVERR_EN: out-of-range accesses return PSLVERR=1.
module apb_field_bank #(
    parameter int unsigned               G_ADDR_WIDTH = 6,
    parameter int unsigned               N_REGS       = 8,
    parameter int unsigned               FIELD_W      = 8,
    parameter logic [2*N_REGS-1:0]       MODE         = '0,
    parameter logic [N_REGS*FIELD_W-1:0] RESET_VAL    = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_apb_psel,
    input  logic                        s_apb_penable,
    input  logic                        s_apb_pwrite,
    input  logic [2:0]                  s_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]     s_apb_paddr,
    input  logic [31:0]                 s_apb_pwdata,
    input  logic [3:0]                  s_apb_pstrb,
    output logic                        s_apb_pready,
    output logic [31:0]                 s_apb_prdata,
    output logic                        s_apb_pslverr,
    input  logic [N_REGS*FIELD_W-1:0]   hwif_in_next,
    input  logic [N_REGS-1:0]           hwif_in_we,
    output logic [N_REGS*FIELD_W-1:0]   hwif_out_value,
    output logic                        irq
);

    localparam int unsigned IDX_W   = G_ADDR_WIDTH - 2;
    localparam logic [1:0]  M_RW    = 2'd0;
    localparam logic [1:0]  M_HWWE  = 2'd1;
    localparam logic [1:0]  M_HWWEL = 2'd2;

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t               state_q, state_d;
    logic [FIELD_W-1:0]   val_q [N_REGS];
    logic [FIELD_W-1:0]   val_d [N_REGS];
    logic                 pready_q, pready_d;
    logic [31:0]          prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic                 irq_q, irq_d;

    logic [IDX_W-1:0]     idx;
    logic                 in_range;
    logic                 access;
    logic                 sw_wr;
    logic [FIELD_W-1:0]   wr_mask;
    logic [FIELD_W-1:0]   wr_data;
    logic [FIELD_W-1:0]   rd_field;

    // Address decode, byte-lane mask and read mux
    always_comb begin
        idx      = s_apb_paddr[G_ADDR_WIDTH-1:2];
        in_range = (32'(idx) < N_REGS);
        access   = (state_q == ST_IDLE) && s_apb_psel && s_apb_penable;
        sw_wr    = access && s_apb_pwrite && in_range;
        wr_data  = s_apb_pwdata[FIELD_W-1:0];
        wr_mask  = '0;
        for (int unsigned b = 0; b < FIELD_W; b++) begin
            wr_mask[b] = s_apb_pstrb[2'(b >> 3)];
        end
        rd_field = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (in_range && (32'(idx) == i)) begin
                rd_field = val_q[i];
            end
        end
    end

    // Per-register next value: hardware load or sticky set takes precedence
    always_comb begin : reg_next
        logic               hit;
        logic [FIELD_W-1:0] hw_next;
        logic [FIELD_W-1:0] sw_val;
        logic [FIELD_W-1:0] clr;
        logic [FIELD_W-1:0] set;
        hit     = 1'b0;
        hw_next = '0;
        sw_val  = '0;
        clr     = '0;
        set     = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            hit      = sw_wr && (32'(idx) == i);
            hw_next  = hwif_in_next[i*FIELD_W +: FIELD_W];
            sw_val   = (val_q[i] & ~wr_mask) | (wr_data & wr_mask);
            val_d[i] = val_q[i];
            case (MODE[2*i +: 2])
                M_RW: begin
                    if (hit) val_d[i] = sw_val;
                end
                M_HWWE: begin
                    if (hwif_in_we[i])  val_d[i] = hw_next;
                    else if (hit)       val_d[i] = sw_val;
                end
                M_HWWEL: begin
                    if (!hwif_in_we[i]) val_d[i] = hw_next;
                    else if (hit)       val_d[i] = sw_val;
                end
                default: begin
                    clr      = hit ? (wr_data & wr_mask) : '0;
                    set      = hwif_in_we[i] ? hw_next : '0;
                    val_d[i] = (val_q[i] & ~clr) | set;
                end
            endcase
        end
    end

    // Control FSM and registered APB response
    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d  = ST_ACK;
                    pready_d = 1'b1;
                    if (!s_apb_pwrite) prdata_d = 32'(rd_field);
`ifdef APB_FIELD_BANK_SLVERR_EN
                    pslverr_d = !in_range;
`endif
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Interrupt: any set bit in any sticky register, delayed one cycle
    always_comb begin
        irq_d = 1'b0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (MODE[2*i +: 2] == 2'd3) irq_d = irq_d | (|val_q[i]);
        end
    end

    // State and value registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                val_q[i] <= RESET_VAL[i*FIELD_W +: FIELD_W];
            end
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                val_q[i] <= val_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_out
        assign hwif_out_value[g*FIELD_W +: FIELD_W] = val_q[g];
    end

    assign s_apb_pready  = pready_q;
    assign s_apb_prdata  = prdata_q;
    assign s_apb_pslverr = pslverr_q;
    assign irq           = irq_q;

    // Protection bits, address byte offset and upper data lanes carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s_apb_pprot, s_apb_paddr[1:0], s_apb_pwdata, s_apb_pstrb,
                         hwif_in_next, hwif_in_we};

endmodule
